reg_file_param: RTL and testbench

- Parametrised general-purpose register file for the single-cycle datapath; next generation of the fixed 32x32 register file.
- Configurable data width and depth; two combinational read ports, one write port, register 0 hardwired to zero.
- Asynchronous active-low reset clears all entries.
- Adds a handshaked sequential dump port so the bench or debug logic can stream the whole register contents without simulation-only print statements.

---
 rtl/reg_file_param.sv | 158 +++++++++++++++
 tb/tb_reg_file_param.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_param.sv
// Parametrised register file: two combinational read ports, one write port,
// entry 0 hardwired to zero, plus a valid/ready dump port that streams every
// entry in index order.
// Build option: define REG_FILE_BYPASS_EN to forward same-cycle write data
// to the read ports and the dump port. Left undefined, these ports return the
// stored (pre-write) value until after the clock edge.
//
// Dump FSM states:
//   state     | meaning
//   ST_IDLE   | no dump in progress, waiting for dump_start
//   ST_SEND   | presenting entry[cnt] on the dump port, advance on dump_ready
//   ST_DONE   | one-cycle dump_done pulse, then back to ST_IDLE
module reg_file_param #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              regwrite,
   input  logic [ADDR_W-1:0] writereg,
   input  logic [DATA_W-1:0] writeda,
   input  logic [ADDR_W-1:0] readreg1,
   output logic [DATA_W-1:0] readda1,
   input  logic [ADDR_W-1:0] readreg2,
   output logic [DATA_W-1:0] readda2,
   input  logic              dump_start,
   output logic              dump_busy,
   output logic              dump_valid,
   input  logic              dump_ready,
   output logic [ADDR_W-1:0] dump_idx,
   output logic [DATA_W-1:0] dump_data,
   output logic              dump_done
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_DONE = 2'd2
   } dump_state_e;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];

   dump_state_e       state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic              busy_q, busy_d;
   logic              valid_q, valid_d;
   logic              done_q, done_d;

   logic              wr_en;
   logic [DATA_W-1:0] rd1_raw, rd2_raw, dump_raw;

   // Address 0 is never stored, so it stays zero without a special read path.
   assign wr_en = regwrite && (writereg != '0);

   // Next register contents: single write port.
   always_comb begin
      mem_d = mem_q;
      if (wr_en) begin
         mem_d[writereg] = writeda;
      end
   end

   // Register storage, cleared by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         mem_q <= mem_d;
      end
   end

   // Raw read values for both read ports and the dump port, with optional forwarding.
   always_comb begin
      rd1_raw  = mem_q[readreg1];
      rd2_raw  = mem_q[readreg2];
      dump_raw = mem_q[cnt_q];
`ifdef REG_FILE_BYPASS_EN
      if (wr_en && (readreg1 == writereg)) begin
         rd1_raw = writeda;
      end
      if (wr_en && (readreg2 == writereg)) begin
         rd2_raw = writeda;
      end
      if (wr_en && (cnt_q == writereg)) begin
         dump_raw = writeda;
      end
`endif
   end

   assign readda1 = (readreg1 == '0) ? '0 : rd1_raw;
   assign readda2 = (readreg2 == '0) ? '0 : rd2_raw;

   // Dump sequencing: next state, index counter and registered status flags.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (dump_start) begin
               state_d = ST_SEND;
               cnt_d   = '0;
            end
         end
         ST_SEND: begin
            // Compare before incrementing so the counter never wraps mid-dump.
            if (dump_ready) begin
               if (cnt_q == LAST_IDX) begin
                  state_d = ST_DONE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + ADDR_W'(1);
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
      busy_d  = (state_d == ST_SEND);
      valid_d = (state_d == ST_SEND);
      done_d  = (state_d == ST_DONE);
   end

   // Dump state, counter and status flags; reset aborts any dump in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         valid_q <= valid_d;
         done_q  <= done_d;
      end
   end

   assign dump_busy  = busy_q;
   assign dump_valid = valid_q;
   assign dump_done  = done_q;
   assign dump_idx   = cnt_q;
   // Data tracks the live entry so a write landing during a stall is visible.
   assign dump_data  = valid_q ? dump_raw : '0;

endmodule

// File: tb/tb_reg_file_param.sv
// Scoreboard bench for reg_file_param: the driver pushes expected read data
// and expected dump indices; a negedge monitor pops and compares them against
// a plain array model of the register contents.
module tb_reg_file_param;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int DEPTH  = 32;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              regwrite;
   logic [ADDR_W-1:0] writereg;
   logic [DATA_W-1:0] writeda;
   logic [ADDR_W-1:0] readreg1, readreg2;
   logic [DATA_W-1:0] readda1, readda2;
   logic              dump_start, dump_busy, dump_valid, dump_ready, dump_done;
   logic [ADDR_W-1:0] dump_idx;
   logic [DATA_W-1:0] dump_data;

   always #5 clk = ~clk;

   reg_file_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .regwrite(regwrite), .writereg(writereg), .writeda(writeda),
      .readreg1(readreg1), .readda1(readda1),
      .readreg2(readreg2), .readda2(readda2),
      .dump_start(dump_start), .dump_busy(dump_busy), .dump_valid(dump_valid),
      .dump_ready(dump_ready), .dump_idx(dump_idx), .dump_data(dump_data),
      .dump_done(dump_done)
   );

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int start_cyc = 0;
   int exp_done_cyc = -1;
   int done_cnt = 0;
   bit chk_aa = 1'b0;

   logic [DATA_W-1:0] model [DEPTH];
   logic [DATA_W-1:0] rd1_q[$];
   logic [DATA_W-1:0] rd2_q[$];
   logic [ADDR_W-1:0] idx_q[$];

   // Reference contents: a write to a nonzero address lands at the clock edge.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) model[i] <= '0;
      end else if (regwrite && writereg != 0) begin
         model[writereg] <= writeda;
      end
   end

   always @(posedge clk) cyc <= cyc + 1;

   // What any read of address a should return right now.
   function automatic logic [DATA_W-1:0] exp_rd(input logic [ADDR_W-1:0] a);
      if (a == 0) return '0;
`ifdef REG_FILE_BYPASS_EN
      if (regwrite && writereg == a) return writeda;
`endif
      return model[a];
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply(input bit we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic [4:0] r1, input logic [4:0] r2,
                        input bit rdy, input bit st);
      regwrite = we; writereg = wa; writeda = wd;
      readreg1 = r1; readreg2 = r2;
      dump_ready = rdy; dump_start = st;
   endtask

   task automatic drive(input bit we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic [4:0] r1, input logic [4:0] r2,
                        input bit rdy, input bit st);
      tick();
      apply(we, wa, wd, r1, r2, rdy, st);
   endtask

   task automatic push_model();
      rd1_q.push_back(exp_rd(readreg1));
      rd2_q.push_back(exp_rd(readreg2));
   endtask

   task automatic push_const(input logic [31:0] e1, input logic [31:0] e2);
      rd1_q.push_back(e1);
      rd2_q.push_back(e2);
   endtask

   task automatic issue_dump();
      start_cyc = cyc;
      for (int i = 0; i < DEPTH; i++) idx_q.push_back(5'(i));
   endtask

   // Monitor: pops read expectations and checks the dump port every cycle.
   always @(negedge clk) begin
      if (!rst_n) begin
         rd1_q.delete();
         rd2_q.delete();
         idx_q.delete();
         exp_done_cyc = -1;
      end else begin
         bit exp_v;
         if (rd1_q.size() > 0) begin
            chk("readda1", readda1, rd1_q.pop_front());
            chk("readda2", readda2, rd2_q.pop_front());
         end
         exp_v = (idx_q.size() > 0) && (cyc > start_cyc);
         chk("dump_valid", {31'b0, dump_valid}, {31'b0, exp_v});
         chk("dump_busy", {31'b0, dump_busy}, {31'b0, exp_v});
         chk("dump_done", {31'b0, dump_done}, {31'b0, cyc == exp_done_cyc});
         if (exp_v && dump_valid) begin
            chk("dump_idx", {27'b0, dump_idx}, {27'b0, idx_q[0]});
            chk("dump_data", dump_data, exp_rd(idx_q[0]));
            if (dump_ready) begin
               if (chk_aa && idx_q[0] == 5) chk("beat5_data", dump_data, 32'hAA);
               void'(idx_q.pop_front());
               if (idx_q.size() == 0) exp_done_cyc = cyc + 1;
            end
         end
         if (dump_done) done_cnt++;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int  p;
      bit  w5, found;
      logic [4:0] wa, ra;

      apply(0, 0, 0, 0, 0, 0, 0);
      rst_n = 1'b0;
      #2;
      chk("rst_busy", {31'b0, dump_busy}, 0);
      chk("rst_valid", {31'b0, dump_valid}, 0);
      chk("rst_done", {31'b0, dump_done}, 0);
      chk("rst_idx", {27'b0, dump_idx}, 0);
      chk("rst_data", dump_data, 0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;

      for (int i = 0; i < DEPTH; i++) begin
         drive(0, 0, 0, 5'(i), 5'(DEPTH - 1 - i), 0, 0);
         push_const(0, 0);
      end

      drive(1, 9, 32'hDEADBEEF, 0, 0, 0, 0); push_model();
      drive(1, 10, 32'h10, 9, 0, 0, 0);      push_model();
      drive(0, 0, 0, 9, 10, 0, 0);           push_const(32'hDEADBEEF, 32'h10);
      drive(1, 0, 32'hFFFFFFFF, 0, 9, 0, 0); push_model();
      drive(0, 0, 0, 0, 0, 0, 0);            push_const(0, 0);
`ifdef REG_FILE_BYPASS_EN
      drive(1, 17, 32'h1234, 17, 17, 0, 0);  push_const(32'h1234, 32'h1234);
`else
      drive(1, 17, 32'h1234, 17, 17, 0, 0);  push_const(0, 0);
`endif
      drive(0, 0, 0, 17, 17, 0, 0);          push_const(32'h1234, 32'h1234);

      // Random traffic, reads biased toward the write address.
      for (int k = 0; k < 200; k++) begin
         wa = 5'($urandom);
         ra = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
         drive(1'($urandom), wa, $urandom, ra, 5'($urandom), 0, 0);
         push_model();
      end

      // Dump 1: rN = N, consumer always ready.
      for (int n = 0; n < DEPTH; n++) begin
         drive(1, 5'(n), n, 5'($urandom), 5'($urandom), 1, 0);
         push_model();
      end
      drive(0, 0, 0, 5'($urandom), 5'($urandom), 1, 1); push_model();
      issue_dump();
      for (int k = 0; k < 200 && idx_q.size() != 0; k++) begin
         drive(0, 0, 0, 5'($urandom), 5'($urandom), 1, 0);
         push_model();
      end
      chk("dump1_complete", idx_q.size(), 0);
      repeat (3) begin drive(0, 0, 0, 5'($urandom), 5'($urandom), 1, 0); push_model(); end
      chk("dump1_done_cnt", done_cnt, 1);

      // Dump 2: ready 1,0,0 pattern, writes during the dump, r5 rewritten while stalled.
      chk_aa = 1'b1;
      w5 = 1'b0;
      drive(0, 0, 0, 5'($urandom), 5'($urandom), 0, 1); push_model();
      issue_dump();
      p = 0;
      for (int k = 0; k < 400 && idx_q.size() != 0; k++) begin
         bit rdy, st, we;
         logic [31:0] wd;
         tick();
         rdy = (p % 3 == 0);
         p++;
         st = (idx_q.size() >= 2) && (cyc > start_cyc) && ($urandom_range(0, 3) == 0);
         if (!rdy && dump_valid && dump_idx == 5 && !w5) begin
            we = 1; wa = 5; wd = 32'hAA; w5 = 1'b1;
         end else begin
            we = 1'($urandom);
            wa = 5'($urandom_range(1, 31));
            if (wa == 5) wa = 6;
            wd = $urandom;
         end
         apply(we, wa, wd, ($urandom_range(0, 1) == 0) ? wa : 5'($urandom), 5'($urandom), rdy, st);
         push_model();
      end
      chk("dump2_complete", idx_q.size(), 0);
      repeat (3) begin drive(0, 0, 0, 5, 5'($urandom), 0, 0); push_model(); end
      chk("dump2_done_cnt", done_cnt, 2);
      chk_aa = 1'b0;

      // Dump 3: reset while beat 12 is presented.
      drive(0, 0, 0, 0, 0, 1, 1); push_model();
      issue_dump();
      found = 1'b0;
      for (int k = 0; k < 100; k++) begin
         tick();
         if (dump_valid && dump_idx == 12) begin
            found = 1'b1;
            break;
         end
         apply(1'($urandom), 5'($urandom), $urandom, 5'($urandom), 5'($urandom), 1, 0);
         push_model();
      end
      chk("reach_idx12", {31'b0, found}, 1);
      apply(0, 0, 0, 0, 0, 1, 0);
      rst_n = 1'b0;
      #1;
      chk("abort_busy", {31'b0, dump_busy}, 0);
      chk("abort_valid", {31'b0, dump_valid}, 0);
      chk("abort_done", {31'b0, dump_done}, 0);
      chk("abort_idx", {27'b0, dump_idx}, 0);
      chk("abort_data", dump_data, 0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         drive(0, 0, 0, 5'(i), 5'(DEPTH - 1 - i), 1, 0);
         push_const(0, 0);
      end
      chk("abort_done_cnt", done_cnt, 2);

      // Dump 4: fresh dump after reset starts again at index 0.
      drive(1, 3, 32'h33, 0, 0, 1, 1); push_model();
      issue_dump();
      for (int k = 0; k < 200 && idx_q.size() != 0; k++) begin
         drive(0, 0, 0, 5'($urandom), 5'($urandom), 1, 0);
         push_model();
      end
      chk("dump4_complete", idx_q.size(), 0);
      repeat (3) begin drive(0, 0, 0, 3, 5'($urandom), 1, 0); push_model(); end
      chk("dump4_done_cnt", done_cnt, 3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
